// File: rtl/watch_ctrl_pkg.sv
// Shared encodings and helpers for the stopwatch/watch control FSM.
package watch_ctrl_pkg;

    typedef enum logic [1:0] {
        SW_STOP  = 2'd0,
        SW_RUN   = 2'd1,
        SW_CLEAR = 2'd2
    } sw_state_t;

    // Watch state codes double as the field code driven on w_field.
    typedef enum logic [1:0] {
        W_RUN    = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } w_state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_SEC  = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_HOUR = 2'd3;

    localparam logic [3:0] MASK_SEC = 4'b0011;
    localparam logic [3:0] MASK_HM  = 4'b1100;

    function automatic w_state_t next_field_state(input w_state_t s);
        case (s)
            W_RUN:    return SET_SEC;
            SET_SEC:  return SET_MIN;
            SET_MIN:  return SET_HOUR;
            SET_HOUR: return W_RUN;
        endcase
    endfunction

    function automatic logic [1:0] field_code(input w_state_t s);
        case (s)
            W_RUN:    return FLD_NONE;
            SET_SEC:  return FLD_SEC;
            SET_MIN:  return FLD_MIN;
            SET_HOUR: return FLD_HOUR;
        endcase
    endfunction

    // The display mux shows HH:MM while hours are set, so hours blink the left pair.
    function automatic logic [3:0] field_mask(input w_state_t s);
        case (s)
            SET_SEC:           return MASK_SEC;
            SET_MIN, SET_HOUR: return MASK_HM;
            default:           return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: counts 0..BLINK_HALF-1 and flips phase on each wrap.
module blink_gen #(
    parameter int BLINK_HALF = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase,
    output logic toggle
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt;

    // toggle marks the edge where phase flips; a restart overrides it.
    assign toggle = (cnt == LAST) && !restart;

    // NOTE: asynchronous active-low reset lives in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/watch_ctrl_fsm.sv
// Stopwatch run/stop/clear and watch time-set control with FND blink masks.
// Optional SET-state inactivity timeout enabled by defining SET_TIMEOUT_EN.
module watch_ctrl_fsm
    import watch_ctrl_pkg::*;
#(
    parameter int BLINK_HALF         = 50_000_000,
    parameter int SET_TIMEOUT_BLINKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic       btn_RS,
    input  logic       btn_CLR,
    input  logic       btn_SET,
    input  logic       btn_UP,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       w_hold,
    output logic [1:0] w_field,
    output logic       w_inc,
    output logic [3:0] blink_mask
);

    if (SET_TIMEOUT_BLINKS < 1) begin : g_param_check
        $error("watch_ctrl_fsm: SET_TIMEOUT_BLINKS must be at least 1");
    end

    logic      sw_meta, sw_s;
    sw_state_t sw_state;
    w_state_t  w_state;
    logic      phase, toggle, restart, next_phase, timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    // Restarting on a SET that leaves to W_RUN is harmless: the mask is zero there.
    assign restart    = btn_UP || (sw_s && btn_SET);
    assign next_phase = restart ? 1'b0 : (phase ^ toggle);

    blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .phase   (phase),
        .toggle  (toggle)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_state <= SW_STOP;
            sw_run   <= 1'b0;
            sw_clear <= 1'b0;
        end else begin
            // NOTE: a default non-blocking assignment first, later ones in the same block win.
            sw_clear <= 1'b0;
            case (sw_state)
                SW_STOP: begin
                    if (!sw_s && btn_CLR) begin
                        sw_state <= SW_CLEAR;
                        sw_clear <= 1'b1;
                    end else if (!sw_s && btn_RS) begin
                        sw_state <= SW_RUN;
                        sw_run   <= 1'b1;
                    end
                end
                SW_RUN: begin
                    if (!sw_s && btn_RS) begin
                        sw_state <= SW_STOP;
                        sw_run   <= 1'b0;
                    end
                end
                default: sw_state <= SW_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state    <= W_RUN;
            w_hold     <= 1'b0;
            w_field    <= FLD_NONE;
            w_inc      <= 1'b0;
            blink_mask <= 4'b0000;
        end else begin
            w_inc <= 1'b0;
            if (!sw_s || timeout) begin
                w_state    <= W_RUN;
                w_hold     <= 1'b0;
                w_field    <= FLD_NONE;
                blink_mask <= 4'b0000;
            end else if (btn_SET) begin
                w_state    <= next_field_state(w_state);
                w_hold     <= (next_field_state(w_state) != W_RUN);
                w_field    <= field_code(next_field_state(w_state));
                blink_mask <= 4'b0000;
            end else if (btn_UP && w_state != W_RUN) begin
                w_inc      <= 1'b1;
                blink_mask <= 4'b0000;
            end else begin
                // sw_meta is next cycle's sw_s, so the mask drops with the switch.
                blink_mask <= (w_state != W_RUN && sw_meta && next_phase)
                              ? field_mask(w_state) : 4'b0000;
            end
        end
    end

`ifdef SET_TIMEOUT_EN
    localparam int TW = $clog2(SET_TIMEOUT_BLINKS + 1);
    logic [TW-1:0] tcnt;

    // SET and UP cannot coincide with a toggle: both restart the blink counter.
    assign timeout = (w_state != W_RUN) && sw_s && toggle
                     && (tcnt == TW'(SET_TIMEOUT_BLINKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (w_state == W_RUN || !sw_s || btn_SET || btn_UP || timeout) begin
            tcnt <= '0;
        end else if (toggle) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_watch_ctrl_fsm.sv
// Self-checking bench: directed scenarios then random buttons/switch against a behavioural model.
module tb_watch_ctrl_fsm;

    localparam int BH = 4;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw = 1'b0;
    logic       btn_RS = 1'b0, btn_CLR = 1'b0, btn_SET = 1'b0, btn_UP = 1'b0;
    logic       sw_run, sw_clear, w_hold, w_inc;
    logic [1:0] w_field;
    logic [3:0] blink_mask;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: time since last blink restart, field index, stopwatch mode.
    bit   m_sw1, m_sw2, m_running, m_clearing, e_clear, e_inc;
    int   m_field, m_age;
    logic [3:0] e_mask;

    watch_ctrl_fsm #(.BLINK_HALF(BH), .SET_TIMEOUT_BLINKS(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_RS     (btn_RS),
        .btn_CLR    (btn_CLR),
        .btn_SET    (btn_SET),
        .btn_UP     (btn_UP),
        .sw_run     (sw_run),
        .sw_clear   (sw_clear),
        .w_hold     (w_hold),
        .w_field    (w_field),
        .w_inc      (w_inc),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sw1 = 0; m_sw2 = 0; m_running = 0; m_clearing = 0;
        e_clear = 0; e_inc = 0; m_field = 0; m_age = 0; e_mask = 4'b0000;
    endtask

    task automatic model_edge(input bit rs, input bit clr, input bit set, input bit up);
        bit s;
        s = m_sw2;
        e_clear = 0;
        if (m_clearing) m_clearing = 0;
        else if (!s) begin
            if (!m_running && clr) begin
                m_clearing = 1;
                e_clear    = 1;
            end else if (rs) m_running = !m_running;
        end
        e_inc = 0;
        if (up || (s && set)) m_age = 0;
        else m_age++;
        if (!s) m_field = 0;
        else if (set) m_field = (m_field + 1) % 4;
        else if (up && m_field != 0) e_inc = 1;
`ifdef SET_TIMEOUT_EN
        else if (m_field != 0 && m_age == BH * TO) m_field = 0;
`endif
        m_sw2 = m_sw1;
        m_sw1 = sw;
        e_mask = (m_field != 0 && m_sw2 && ((m_age / BH) % 2 == 1))
                 ? ((m_field == 1) ? 4'b0011 : 4'b1100) : 4'b0000;
    endtask

    task automatic check_outputs();
        check("sw_run",     32'(sw_run),     32'(m_running));
        check("sw_clear",   32'(sw_clear),   32'(e_clear));
        check("w_hold",     32'(w_hold),     32'(m_field != 0));
        check("w_field",    32'(w_field),    32'(m_field));
        check("w_inc",      32'(w_inc),      32'(e_inc));
        check("blink_mask", 32'(blink_mask), 32'(e_mask));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sw_run"},     32'(sw_run),     32'd0);
        check({tag, "_sw_clear"},   32'(sw_clear),   32'd0);
        check({tag, "_w_hold"},     32'(w_hold),     32'd0);
        check({tag, "_w_field"},    32'(w_field),    32'd0);
        check({tag, "_w_inc"},      32'(w_inc),      32'd0);
        check({tag, "_blink_mask"}, 32'(blink_mask), 32'd0);
    endtask

    // Buttons are driven just after an edge, held through the next edge, then released.
    task automatic step(input bit rs, input bit clr, input bit set, input bit up);
        btn_RS = rs; btn_CLR = clr; btn_SET = set; btn_UP = up;
        @(posedge clk);
        model_edge(rs, clr, set, up);
        #1;
        check_outputs();
        btn_RS = 0; btn_CLR = 0; btn_SET = 0; btn_UP = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Stopwatch run/stop/clear
        step(1, 0, 0, 0); idle(2);
        step(1, 0, 0, 0); idle(2);
        step(0, 1, 0, 0); idle(3);
        // CLR ignored while running, RS+CLR in STOP clears
        step(1, 0, 0, 0); idle(1);
        step(0, 1, 0, 0); idle(1);
        step(1, 0, 0, 0); idle(1);
        step(1, 1, 0, 0); idle(3);

        // Watch field cycling and blink
        sw = 1'b1; idle(3);
        step(0, 0, 1, 0); idle(12);
        step(0, 0, 1, 0); idle(2);
        step(0, 0, 1, 0); idle(2);
        step(0, 0, 1, 0); idle(2);
        step(0, 0, 0, 1); idle(2);          // UP in W_RUN ignored

        // UP in SET_MIN, then SET+UP together
        step(0, 0, 1, 0); step(0, 0, 1, 0); idle(6);
        step(0, 0, 0, 1); idle(9);
        step(0, 0, 1, 1); idle(3);
        step(0, 0, 1, 0); idle(2);

        // Background stopwatch and switch falling in a SET state
        sw = 1'b0; idle(3);
        step(1, 0, 0, 0); idle(1);
        sw = 1'b1; idle(3);
        step(0, 0, 1, 0); idle(6);
        sw = 1'b0; idle(3);
        step(1, 0, 0, 0); idle(2);

        // Timeout (or persistence) in SET_SEC, then reset mid-SET
        sw = 1'b1; idle(3);
        step(0, 0, 1, 0); idle(100);
        if (m_field == 0) begin
            step(0, 0, 1, 0); idle(5);
        end
        #2 rst = 1'b0;
        #1 check_all_zero("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) sw = ~sw;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
